// File: rtl/ac97_pkg.sv
// Shared AC'97 link constants, types and slot helpers.
// Used by the mic capture path and the output serializer.
package ac97_pkg;

  localparam int FRAME_BITS = 256;
  localparam int TAG_BITS   = 16;
  localparam int SLOT_BITS  = 20;

  typedef logic [$clog2(FRAME_BITS)-1:0] bit_idx_t;
  typedef logic signed [SLOT_BITS-1:0]   sample_t;

  localparam bit_idx_t IDLE_BIT = bit_idx_t'(FRAME_BITS - 1);

  function automatic bit_idx_t slot_start(input int n);
    return bit_idx_t'(TAG_BITS + SLOT_BITS * (n - 1));
  endfunction

endpackage

// File: rtl/ac97_mic_level_if.sv
// Codec link inputs and captured sample / level outputs.
// master = codec side, slave = ac97_mic_level.
interface ac97_mic_level_if;
  import ac97_pkg::*;

  logic                 BitClk;
  logic                 Sync;
  logic                 SDataIn;
  sample_t              Sample;
  logic                 SampleValid;
  logic [SLOT_BITS-1:0] Level;
  logic                 Locked;

  modport master (
    output BitClk, Sync, SDataIn,
    input  Sample, SampleValid, Level, Locked
  );

  modport slave (
    input  BitClk, Sync, SDataIn,
    output Sample, SampleValid, Level, Locked
  );

endinterface

// File: rtl/ac97_bit_sync.sv
// Brings BIT_CLK, SYNC and SDATA into the system clock domain.
// strobe marks a synchronized BIT_CLK falling edge.
module ac97_bit_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic bit_clk,
  input  logic sync,
  input  logic sdata,
  output logic strobe,
  output logic sync_s,
  output logic sdata_s
);

  logic [2:0] bclk_q;
  logic [1:0] sync_q;
  logic [1:0] sdata_q;

  // Two-flop synchronizers; bclk keeps one extra stage for edge detect
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bclk_q  <= '0;
      sync_q  <= '0;
      sdata_q <= '0;
    end else begin
      bclk_q  <= {bclk_q[1:0], bit_clk};
      sync_q  <= {sync_q[0], sync};
      sdata_q <= {sdata_q[0], sdata};
    end
  end

  assign strobe  = bclk_q[2] & ~bclk_q[1];
  assign sync_s  = sync_q[1];
  assign sdata_s = sdata_q[1];

endmodule

// File: rtl/ac97_mic_level.sv
// Captures one AC'97 ADC slot per frame and tracks a
// peak-hold, decaying magnitude envelope of it.
module ac97_mic_level
  import ac97_pkg::*;
#(
  parameter int SLOT          = 6,
  parameter int DECAY_SAMPLES = 48,
  parameter int DECAY_SHIFT   = 4,
  parameter int LOCK_FRAMES   = 2
) (
  input logic             Clock,
  input logic             Reset_B,
  ac97_mic_level_if.slave link
);

  localparam bit_idx_t FIRST   = slot_start(SLOT);
  localparam bit_idx_t LAST    = bit_idx_t'(int'(FIRST) + SLOT_BITS - 1);
  localparam bit_idx_t TAG_POS = bit_idx_t'(SLOT);

  logic                 strobe, sync_s, sdata_s;
  logic                 sync_prev, armed;
  logic                 sync_rise, in_frame, in_slot;
  bit_idx_t             bit_cnt, nxt_idx;
  logic [7:0]           idle_cnt, align_cnt;
  logic                 frame_v, slot_v;
  logic [SLOT_BITS-1:0] shift, shift_nxt;
  sample_t              sample;
  logic                 sample_valid;
  logic [SLOT_BITS-1:0] level, lvl_nxt;
  logic [SLOT_BITS-1:0] s_u, mag, peak;
  logic [15:0]          dcnt;
  logic                 decay_due;

  ac97_bit_sync u_sync (
    .clk     (Clock),
    .rst_n   (Reset_B),
    .bit_clk (link.BitClk),
    .sync    (link.Sync),
    .sdata   (link.SDataIn),
    .strobe  (strobe),
    .sync_s  (sync_s),
    .sdata_s (sdata_s)
  );

  // Index of the bit arriving on this strobe; 255 holds when idle
  always_comb begin
    sync_rise = strobe & sync_s & ~sync_prev;
    in_frame  = (bit_cnt != IDLE_BIT) | armed;
    nxt_idx   = bit_cnt + bit_idx_t'(1);
    if (!in_frame) nxt_idx = IDLE_BIT;
    in_slot   = (nxt_idx >= FIRST) && (nxt_idx <= LAST);
    shift_nxt = {shift[SLOT_BITS-2:0], sdata_s};
  end

  // Bit counter, SYNC alignment tracking and lock/loss detection
  always_ff @(posedge Clock) begin
    if (!Reset_B) begin
      sync_prev <= 1'b0;
      bit_cnt   <= IDLE_BIT;
      armed     <= 1'b0;
      idle_cnt  <= '0;
      align_cnt <= '0;
    end else if (strobe) begin
      sync_prev <= sync_s;
      if (sync_rise) begin
        bit_cnt  <= IDLE_BIT;
        armed    <= 1'b1;
        idle_cnt <= '0;
        if (bit_cnt == IDLE_BIT - bit_idx_t'(1)) begin
          if (align_cnt != 8'hff) align_cnt <= align_cnt + 8'd1;
        end else if (bit_cnt != IDLE_BIT) begin
          align_cnt <= '0;
        end
      end else begin
        bit_cnt <= nxt_idx;
        armed   <= 1'b0;
        if (!in_frame) begin
          if (idle_cnt == 8'hff) align_cnt <= '0;
          else idle_cnt <= idle_cnt + 8'd1;
        end
      end
    end
  end

  // Tag latching, slot shift-in and sample hand-off
  always_ff @(posedge Clock) begin
    if (!Reset_B) begin
      frame_v      <= 1'b0;
      slot_v       <= 1'b0;
      shift        <= '0;
      sample       <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (strobe && !sync_rise && in_frame) begin
        if (nxt_idx == '0) frame_v <= sdata_s;
        if (nxt_idx == TAG_POS) slot_v <= sdata_s;
        if (in_slot) shift <= shift_nxt;
        if (nxt_idx == LAST && frame_v && slot_v) begin
          sample       <= shift_nxt;
          sample_valid <= 1'b1;
        end
      end
    end
  end

  // Magnitude and envelope candidate; a stalled decay snaps to mag
  always_comb begin
    s_u = sample;
    mag = s_u;
    if (s_u[SLOT_BITS-1]) begin
      mag = (s_u == {1'b1, {(SLOT_BITS-1){1'b0}}})
          ? {1'b0, {(SLOT_BITS-1){1'b1}}}
          : ~s_u + 1'b1;
    end
    decay_due = (dcnt == 16'(DECAY_SAMPLES - 1));
    peak      = decay_due ? level - (level >> DECAY_SHIFT) : level;
    lvl_nxt   = (peak > mag) ? peak : mag;
    if (decay_due && peak == level) lvl_nxt = mag;
  end

  // Envelope register and decay pacing, advanced per valid sample
  always_ff @(posedge Clock) begin
    if (!Reset_B) begin
      level <= '0;
      dcnt  <= '0;
    end else if (sample_valid) begin
      level <= lvl_nxt;
      dcnt  <= decay_due ? '0 : dcnt + 16'd1;
    end
  end

  assign link.Sample      = sample;
  assign link.SampleValid = sample_valid;
  assign link.Level       = level;
  assign link.Locked      = align_cnt >= 8'(LOCK_FRAMES);

endmodule
